mac_job_sequencer: RTL
======================

Name: mac_job_sequencer

Overview:
- Control FSM that sequences one MAC datapath job at a time.
- Accepts a job descriptor, latches the datapath configuration (simple_mul, shift), and issues one length request to the input/output streamers.
- Holds the datapath start level high while the job runs, counts a/b input handshakes and d output handshakes, then pulses a done event.
- Sits between the register-file/controller slave and the MAC datapath plus streamers inside the HWPE engine.

Parameters:
- CNT_W, 16, width of the job length and all handshake counters; the maximum job length is 2^CNT_W-1.
- SHIFT_W, 5, width of the shift field; matches the datapath shift input.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous soft abort; returns the FSM to IDLE
- cfg_valid_i  in  1  job descriptor valid
- cfg_ready_o  out  1  descriptor accepted; high only in IDLE
- cfg_len_i  in  CNT_W  number of a/b operand pairs
- cfg_simple_mul_i  in  1  1 = element-wise multiply, 0 = scalar product
- cfg_shift_i  in  SHIFT_W  datapath shift amount
- strm_req_valid_o  out  1  streamer length request valid
- strm_req_ready_i  in  1  streamers accept the request
- strm_in_len_o  out  CNT_W  a/b/c beats to fetch (= len)
- strm_out_len_o  out  CNT_W  d beats to store
- mac_start_o  out  1  datapath start/enable level
- mac_simple_mul_o  out  1  latched mode
- mac_shift_o  out  SHIFT_W  latched shift
- ab_hs_i  in  1  a_i.valid & a_i.ready & b_i.valid & b_i.ready, tapped from the datapath
- d_hs_i  in  1  d_o.valid & d_o.ready, tapped from the datapath
- busy_o  out  1  FSM not in IDLE
- evt_done_o  out  1  one-cycle job-complete pulse
- cnt_in_o  out  CNT_W  a/b handshakes counted in the current job
- cnt_out_o  out  CNT_W  d handshakes counted in the current job

Behaviour:
- One clock. Reset is synchronous, active-low on rst_ni, sampled on the rising edge of clk_i.
- Reset values:
  - all outputs 0 except cfg_ready_o = 1
  - state IDLE
  - latched len, mode, shift and both counters = 0
- States: IDLE, REQ, RUN, DONE.
- IDLE:
  - cfg_ready_o = 1.
  - On cfg_valid_i, latch len, simple_mul and shift.
  - If len == 0, go to DONE with no streamer request. Otherwise go to REQ.
- REQ:
  - strm_req_valid_o = 1 with constant strm_in_len_o = len.
  - strm_out_len_o = len if simple_mul, else 1.
  - Hold until strm_req_ready_i, then go to RUN.
  - Valid must not drop before the handshake.
- RUN:
  - mac_start_o = 1.
  - cnt_in increments on ab_hs_i, saturating at len; an extra handshake is ignored.
  - cnt_out increments on d_hs_i.
  - When cnt_out reaches the output length, go to DONE. This includes the cycle where the final d_hs_i and ab_hs_i coincide.
- DONE:
  - evt_done_o = 1 for exactly one cycle; mac_start_o = 0.
  - Next state IDLE. Counters hold their final values until the next accept, then clear to 0.
- Config outputs:
  - mac_simple_mul_o and mac_shift_o are driven from latched registers only and never change while busy_o = 1.
  - A cfg_valid_i asserted while busy_o = 1 is not accepted; the master must hold it.
- clear_i:
  - Takes effect in the same cycle as reset for state and counters. Latched config is retained.
  - No evt_done_o is produced.
  - Asserted in REQ, it drops strm_req_valid_o; the streamers are cleared by the same clear_i.
  - clear_i has priority over all transitions, including DONE.
- Latency:
  - Descriptor accept to strm_req_valid_o = 1 cycle.
  - Final d_hs_i to evt_done_o = 1 cycle.
  - evt_done_o to cfg_ready_o = 1 cycle.
- Arithmetic: counters are unsigned CNT_W; compares are equality against the latched lengths.

Decomposition:
- MAC_package holds:
  - state enum mac_seq_state_t {IDLE, REQ, RUN, DONE}
  - struct mac_seq_cfg_t {len, simple_mul, shift}
  - constant MAC_SEQ_CNT_W
- One sub-module, mac_seq_counter: an enable/clear/saturate up-counter with an equality-match flag. It is instantiated twice, for input and output counting.

Test Plan:
- Simple multiply, len = 4, shift = 2, strm_req_ready_i high after 3 cycles:
  - strm_in_len_o = strm_out_len_o = 4
  - mac_start_o high for the whole RUN state
  - four d_hs_i pulses, then evt_done_o exactly 1 cycle later
  - cnt_in_o = cnt_out_o = 4
- Scalar product, len = 8: strm_out_len_o = 1; eight ab_hs_i then one d_hs_i → DONE; cnt_in_o = 8, cnt_out_o = 1.
- len = 0: IDLE → DONE → IDLE; evt_done_o pulses; strm_req_valid_o and mac_start_o never assert.
- cfg_valid_i held during RUN with a different shift (7 vs latched 2): mac_shift_o stays 2, and the new descriptor is accepted on the first cycle back in IDLE.
- clear_i mid-RUN after 3 of 8 handshakes: state IDLE next cycle, counters 0, no evt_done_o, cfg_ready_o = 1.
- rst_ni low for one cycle during REQ: all outputs return to reset values on that edge; strm_req_valid_o drops immediately.

Source files
------------

// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and constants for the MAC job sequencer and its counters.
package mac_job_sequencer_pkg;

  localparam int unsigned MAC_SEQ_CNT_W   = 16;
  localparam int unsigned MAC_SEQ_SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } mac_seq_state_t;

  typedef struct packed {
    logic [MAC_SEQ_CNT_W-1:0]   len;
    logic                       simple_mul;
    logic [MAC_SEQ_SHIFT_W-1:0] shift;
  } mac_seq_cfg_t;

endpackage

// File: rtl/mac_seq_counter.sv
// Saturating up-counter; match_o flags the increment that lands exactly on limit_i.
module mac_seq_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         match_o
);

  logic [W-1:0] cnt_q;
  logic         at_limit;
  logic         step;

  assign at_limit = (cnt_q == limit_i);
  assign step     = en_i & ~at_limit;
  assign cnt_o    = cnt_q;
  // Looks one count ahead so the owner can react on the same edge as the final event.
  assign match_o  = step & ((cnt_q + W'(1)) == limit_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/mac_job_sequencer.sv
// Sequences one MAC datapath job: latch descriptor, request streamers, run, pulse done.
module mac_job_sequencer
  import mac_job_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = MAC_SEQ_CNT_W,
  parameter int unsigned SHIFT_W = MAC_SEQ_SHIFT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CNT_W-1:0]   cfg_len_i,
  input  logic               cfg_simple_mul_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  output logic               strm_req_valid_o,
  input  logic               strm_req_ready_i,
  output logic [CNT_W-1:0]   strm_in_len_o,
  output logic [CNT_W-1:0]   strm_out_len_o,
  output logic               mac_start_o,
  output logic               mac_simple_mul_o,
  output logic [SHIFT_W-1:0] mac_shift_o,
  input  logic               ab_hs_i,
  input  logic               d_hs_i,
  output logic               busy_o,
  output logic               evt_done_o,
  output logic [CNT_W-1:0]   cnt_in_o,
  output logic [CNT_W-1:0]   cnt_out_o
);

  mac_seq_state_t state_q;
  mac_seq_cfg_t   cfg_q;

  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] out_len;
  logic             accept;
  logic             in_match_unused;
  logic             out_match;

  assign len     = CNT_W'(cfg_q.len);
  // Scalar product yields a single result beat; an empty job yields none.
  assign out_len = (len == '0) ? '0 : (cfg_q.simple_mul ? len : CNT_W'(1));
  assign accept  = (state_q == IDLE) & cfg_valid_i;

  assign strm_in_len_o    = len;
  assign strm_out_len_o   = out_len;
  assign mac_simple_mul_o = cfg_q.simple_mul;
  assign mac_shift_o      = SHIFT_W'(cfg_q.shift);

  mac_seq_counter #(.W(CNT_W)) u_cnt_in (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i | accept),
    .en_i    ((state_q == RUN) & ab_hs_i),
    .limit_i (len),
    .cnt_o   (cnt_in_o),
    .match_o (in_match_unused)
  );

  mac_seq_counter #(.W(CNT_W)) u_cnt_out (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i | accept),
    .en_i    ((state_q == RUN) & d_hs_i),
    .limit_i (out_len),
    .cnt_o   (cnt_out_o),
    .match_o (out_match)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      cfg_q            <= '0;
      cfg_ready_o      <= 1'b1;
      strm_req_valid_o <= 1'b0;
      mac_start_o      <= 1'b0;
      busy_o           <= 1'b0;
      evt_done_o       <= 1'b0;
    end else if (clear_i) begin
      // Abort keeps the latched config so the datapath inputs stay stable.
      state_q          <= IDLE;
      cfg_ready_o      <= 1'b1;
      strm_req_valid_o <= 1'b0;
      mac_start_o      <= 1'b0;
      busy_o           <= 1'b0;
      evt_done_o       <= 1'b0;
    end else begin
      evt_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            cfg_q.len        <= MAC_SEQ_CNT_W'(cfg_len_i);
            cfg_q.simple_mul <= cfg_simple_mul_i;
            cfg_q.shift      <= MAC_SEQ_SHIFT_W'(cfg_shift_i);
            cfg_ready_o      <= 1'b0;
            busy_o           <= 1'b1;
            if (cfg_len_i == '0) begin
              state_q    <= DONE;
              evt_done_o <= 1'b1;
            end else begin
              state_q          <= REQ;
              strm_req_valid_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (strm_req_ready_i) begin
            state_q          <= RUN;
            strm_req_valid_o <= 1'b0;
            mac_start_o      <= 1'b1;
          end
        end
        RUN: begin
          if (out_match) begin
            state_q     <= DONE;
            mac_start_o <= 1'b0;
            evt_done_o  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          busy_o      <= 1'b0;
          cfg_ready_o <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
